// File: rtl/bus_slave.sv
// bus_slave: responder end of the bit-serial master/slave bus.
// Receives a serial address (MSB first) with write data aligned to the last
// DATA_WIDTH address bits, commits writes to a local memory, and serves reads
// by strobing slave_valid and shifting the stored word out MSB first.
// All outputs are registered; the memory itself is never reset.
module bus_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic valid,
    input  logic write_en,
    input  logic addr_rx,
    input  logic data_rx,
    output logic slave_ready,
    output logic slave_valid,
    output logic data_tx
);

    localparam int BCW = $clog2(ADDR_WIDTH + 1);
    localparam int SCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(ADDR_WIDTH - 1);
    localparam logic [BCW-1:0] BIT_MAX    = BCW'(ADDR_WIDTH);
    localparam logic [BCW-1:0] DATA_FIRST = BCW'(ADDR_WIDTH - DATA_WIDTH);
    localparam logic [SCW-1:0] SEND_LAST  = SCW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ADDR       = 3'd1,
        S_WRITE      = 3'd2,
        S_READ_MEM   = 3'd3,
        S_READ_VALID = 3'd4,
        S_READ_SEND  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    wr_q, wr_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [SCW-1:0]          send_cnt_q, send_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    ready_q, ready_d;
    logic                    svalid_q, svalid_d;
    logic                    tx_q, tx_d;

    logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   rd_q;

    assign slave_ready = ready_q;
    assign slave_valid = svalid_q;
    assign data_tx     = tx_q;

    // State and registered outputs; reset returns to IDLE and drops any pending write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            bit_cnt_q  <= '0;
            send_cnt_q <= '0;
            shift_q    <= '0;
            ready_q    <= 1'b1;
            svalid_q   <= 1'b0;
            tx_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            bit_cnt_q  <= bit_cnt_d;
            send_cnt_q <= send_cnt_d;
            shift_q    <= shift_d;
            ready_q    <= ready_d;
            svalid_q   <= svalid_d;
            tx_q       <= tx_d;
        end
    end

    // Local memory: commit in WRITE, registered read every cycle (captured in READ_MEM).
    always_ff @(posedge clock) begin
        if (state_q == S_WRITE) begin
            mem_q[addr_q] <= data_q;
        end
        rd_q <= mem_q[addr_q];
    end

    // Next-state logic; an early drop of valid in ADDR aborts back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (valid) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (!valid) begin
                    state_d = S_IDLE;
                end else if (bit_cnt_q == BIT_LAST) begin
                    state_d = wr_q ? S_WRITE : S_READ_MEM;
                end
            end
            S_WRITE:      state_d = S_IDLE;
            S_READ_MEM:   state_d = S_READ_VALID;
            S_READ_VALID: state_d = S_READ_SEND;
            S_READ_SEND: begin
                if (send_cnt_q == SEND_LAST) state_d = S_IDLE;
            end
            default:      state_d = S_IDLE;
        endcase
    end

    // Datapath and next values of the registered outputs.
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = wr_q;
        bit_cnt_d  = bit_cnt_q;
        send_cnt_d = send_cnt_q;
        shift_d    = shift_q;
        tx_d       = 1'b0;
        ready_d    = (state_d == S_IDLE);
        svalid_d   = (state_d == S_READ_VALID);
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    // First bit lands in bit 0 and reaches the MSB after the last shift.
                    addr_d    = {{(ADDR_WIDTH-1){1'b0}}, addr_rx};
                    data_d    = '0;
                    wr_d      = write_en;
                    bit_cnt_d = BCW'(1);
                end
            end
            S_ADDR: begin
                if (valid) begin
                    addr_d = {addr_q[ADDR_WIDTH-2:0], addr_rx};
                    // Write data rides on the last DATA_WIDTH address bits.
                    if (bit_cnt_q >= DATA_FIRST) begin
                        data_d = {data_q[DATA_WIDTH-2:0], data_rx};
                    end
                    if (bit_cnt_q < BIT_MAX) begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            S_READ_VALID: begin
                // rd_q now holds the word read in READ_MEM; first bit goes out next.
                tx_d       = rd_q[DATA_WIDTH-1];
                shift_d    = {rd_q[DATA_WIDTH-2:0], 1'b0};
                send_cnt_d = SCW'(1);
            end
            S_READ_SEND: begin
                if (send_cnt_q != SEND_LAST) begin
                    tx_d       = shift_q[DATA_WIDTH-1];
                    shift_d    = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    send_cnt_d = send_cnt_q + SCW'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_slave.sv
// Directed testbench for bus_slave: writes, reads, abort, mid-read reset,
// back-to-back traffic and input noise in idle-ignored states.
module tb_bus_slave;

    logic clock;
    logic reset;
    logic valid;
    logic write_en;
    logic addr_rx;
    logic data_rx;
    logic slave_ready;
    logic slave_valid;
    logic data_tx;

    int n_cmp = 0;
    int n_err = 0;

    bus_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .write_en    (write_en),
        .addr_rx     (addr_rx),
        .data_rx     (data_rx),
        .slave_ready (slave_ready),
        .slave_valid (slave_valid),
        .data_tx     (data_tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive nbits address bits (first bit in cycle T). write_en is inverted
    // after the first bit to confirm it is only sampled with addr[11].
    task automatic drive(input logic wr, input logic [11:0] a, input logic [7:0] d, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            if (i == 0) check("ready_before_start", {31'b0, slave_ready}, 32'd1);
            if (i == 1) check("ready_fall", {31'b0, slave_ready}, 32'd0);
            valid    = 1'b1;
            write_en = (i == 0) ? wr : ~wr;
            addr_rx  = a[11 - i];
            data_rx  = (i >= 4) ? d[11 - i] : 1'($urandom);
        end
    endtask

    // Full write; hold_valid keeps valid high during the WRITE cycle.
    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input logic hold_valid);
        drive(1'b1, a, d, 12);
        @(negedge clock);                       // T+12: WRITE
        check("write_busy", {31'b0, slave_ready}, 32'd0);
        valid   = hold_valid;
        addr_rx = 1'($urandom);
        data_rx = 1'($urandom);
    endtask

    // Full read with data_rx random throughout; optional valid noise after the address.
    task automatic do_read(input logic [11:0] a, input logic [7:0] exp, input string tag, input logic noise);
        logic [7:0] got;
        logic       sv_seen;
        got     = '0;
        sv_seen = 1'b0;
        drive(1'b0, a, 8'($urandom), 12);
        @(negedge clock);                       // T+12: READ_MEM
        check({tag, "_sv_early"}, {31'b0, slave_valid}, 32'd0);
        valid   = noise ? 1'($urandom) : 1'b0;
        data_rx = 1'($urandom);
        @(negedge clock);                       // T+13: READ_VALID
        check({tag, "_sv_pulse"}, {31'b0, slave_valid}, 32'd1);
        check({tag, "_tx_in_valid"}, {31'b0, data_tx}, 32'd0);
        valid   = noise ? 1'($urandom) : 1'b0;
        for (int i = 0; i < 8; i++) begin       // T+14..T+21
            @(negedge clock);
            got     = {got[6:0], data_tx};
            sv_seen = sv_seen | slave_valid;
            valid   = noise ? 1'($urandom) : 1'b0;
            addr_rx = 1'($urandom);
            data_rx = 1'($urandom);
        end
        check({tag, "_data"}, {24'b0, got}, {24'b0, exp});
        check({tag, "_sv_during_send"}, {31'b0, sv_seen}, 32'd0);
        @(negedge clock);                       // T+22
        check({tag, "_ready_back"}, {31'b0, slave_ready}, 32'd1);
        valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        valid    = 1'b0;
        write_en = 1'b0;
        addr_rx  = 1'b0;
        data_rx  = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", {31'b0, slave_ready}, 32'd1);
        check("rst_svalid", {31'b0, slave_valid}, 32'd0);
        check("rst_tx", {31'b0, data_tx}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", {31'b0, slave_ready}, 32'd1);

        // Basic write then read with minimum spacing.
        do_write(12'h123, 8'hA5, 1'b0);
        do_read(12'h123, 8'hA5, "rd123", 1'b0);

        // Address extremes.
        do_write(12'hFFF, 8'h3C, 1'b0);
        do_write(12'h000, 8'hC3, 1'b0);
        do_read(12'hFFF, 8'h3C, "rdFFF", 1'b0);
        do_read(12'h000, 8'hC3, "rd000", 1'b0);

        // Aborted write after 6 bits leaves memory untouched.
        do_write(12'h010, 8'h11, 1'b0);
        drive(1'b1, 12'h010, 8'hFF, 6);
        @(negedge clock);                       // T+6: valid dropped
        valid = 1'b0;
        @(negedge clock);                       // T+7
        check("abort_ready", {31'b0, slave_ready}, 32'd1);
        do_read(12'h010, 8'h11, "rd010", 1'b0);

        // Reset in the middle of a read's send phase.
        drive(1'b0, 12'h123, 8'h00, 12);
        for (int i = 0; i < 4; i++) begin       // T+12..T+15
            @(negedge clock);
            valid = 1'b0;
        end
        @(negedge clock);                       // T+16
        reset = 1'b1;
        #1;
        check("midrst_svalid", {31'b0, slave_valid}, 32'd0);
        check("midrst_tx", {31'b0, data_tx}, 32'd0);
        check("midrst_ready", {31'b0, slave_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        do_read(12'h123, 8'hA5, "rd123_after_rst", 1'b0);

        // Back-to-back: valid held high through WRITE, read starts at once, noisy valid.
        do_write(12'h0AB, 8'h5A, 1'b1);
        do_read(12'h0AB, 8'h5A, "rd0AB_b2b", 1'b1);

        // Reads with random data_rx never disturb stored words.
        do_read(12'h123, 8'hA5, "rd123_again", 1'b0);
        do_read(12'hFFF, 8'h3C, "rdFFF_again", 1'b1);
        do_read(12'h000, 8'hC3, "rd000_again", 1'b0);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
